// File: rtl/shift_sched_pkg.sv
// Types, sizes and helpers shared by the shift scheduler and its stage.
`include "shift_defs.vh"

package shift_sched_pkg;
    localparam int WIDTH = 16;
    localparam int NREQ  = 2;
    localparam int AMT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = `ST_IDLE,
        SHIFT = `ST_SHIFT,
        DONE  = `ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        ROL = `OP_ROL,
        SLL = `OP_SLL,
        ROR = `OP_ROR,
        SRL = `OP_SRL
    } op_t;

    // Last stage index that has to run: position of the highest set amount bit.
    function automatic logic [1:0] msb_idx(input logic [AMT_W-1:0] amt);
        if (amt[3])      return 2'd3;
        else if (amt[2]) return 2'd2;
        else if (amt[1]) return 2'd1;
        else             return 2'd0;
    endfunction
endpackage

// File: rtl/shift_defs.vh
// Shared op-code and state encodings for the iterative shift scheduler.
`ifndef SHIFT_DEFS_VH
`define SHIFT_DEFS_VH
`define OP_ROL   2'b00
`define OP_SLL   2'b01
`define OP_ROR   2'b10
`define OP_SRL   2'b11
`define ST_IDLE  2'b00
`define ST_SHIFT 2'b01
`define ST_DONE  2'b10
`endif

// File: rtl/shift_step.sv
// One stage of the logarithmic shifter: shift or rotate by 2^k when enabled.
module shift_step
    import shift_sched_pkg::*;
(
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       k,
    input  logic [1:0]       op,
    input  logic             en,
    output logic [WIDTH-1:0] out
);
    logic [4:0]         s;
    logic [2*WIDTH-1:0] dbl;
    logic [2*WIDTH-1:0] rl;
    logic [2*WIDTH-1:0] rr;

    always_comb begin
        s   = 5'd1 << k;
        dbl = {in, in};
        rl  = dbl << s;
        rr  = dbl >> s;
        out = in;
        if (en) begin
            case (op)
                ROL:     out = rl[2*WIDTH-1:WIDTH];
                SLL:     out = in << s;
                ROR:     out = rr[WIDTH-1:0];
                default: out = in >> s;
            endcase
        end
    end
endmodule

// File: rtl/shift_sched.sv
// Two-requester round-robin front end around a single reusable shift stage,
// sequencing only the stages whose amount bit can matter.
module shift_sched
    import shift_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [WIDTH-1:0]  req_a0,
    input  logic [AMT_W-1:0]  req_amt0,
    input  logic [1:0]        req_op0,
    input  logic [WIDTH-1:0]  req_a1,
    input  logic [AMT_W-1:0]  req_amt1,
    input  logic [1:0]        req_op1,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [WIDTH-1:0]  rsp_data,
    input  logic              rsp_ready,
    output logic              busy
);
    state_t             state_q, state_d;
    logic               ptr_q, ptr_d;
    logic               id_q, id_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [AMT_W-1:0]   amt_q, amt_d;
    logic [1:0]         op_q, op_d;
    logic [1:0]         k_q, k_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               busy_q, busy_d;
    logic [NREQ-1:0]    grant;
    logic [WIDTH-1:0]   step_out;

    // Ready is offered only in IDLE and is suppressed while reset is held.
    always_comb begin
        grant = '0;
        if (rst_n && state_q == IDLE) begin
            if (&req_valid) grant = ptr_q ? 2'b10 : 2'b01;
            else            grant = req_valid;
        end
    end
    assign req_ready = grant;

    shift_step u_step (
        .in  (work_q),
        .k   (k_q),
        .op  (op_q),
        .en  (amt_q[k_q]),
        .out (step_out)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        work_d  = work_q;
        amt_d   = amt_q;
        op_d    = op_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                if (|grant) begin
                    id_d   = grant[1];
                    ptr_d  = ~grant[1];
                    work_d = grant[1] ? req_a1   : req_a0;
                    amt_d  = grant[1] ? req_amt1 : req_amt0;
                    op_d   = grant[1] ? req_op1  : req_op0;
                    k_d    = 2'd0;
                    state_d = (amt_d == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                work_d = step_out;
                if (k_q == msb_idx(amt_q)) state_d = DONE;
                else                       k_d = k_q + 2'd1;
            end
            DONE: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        rsp_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            id_q        <= 1'b0;
            work_q      <= '0;
            amt_q       <= '0;
            op_q        <= 2'b00;
            k_q         <= 2'd0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            work_q      <= work_d;
            amt_q       <= amt_d;
            op_q        <= op_d;
            k_q         <= k_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_data  = work_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_shift_sched.sv
// Scoreboard bench for shift_sched: accepts push modelled results, a negedge
// monitor pops and compares responses, grants, latency and stability.
module tb_shift_sched;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [15:0] req_a0 = 16'h0, req_a1 = 16'h0;
    logic [3:0]  req_amt0 = 4'h0, req_amt1 = 4'h0;
    logic [1:0]  req_op0 = 2'b00, req_op1 = 2'b00;
    logic        rsp_valid, rsp_id, busy;
    logic [15:0] rsp_data;
    logic        rsp_ready = 1'b0;

    localparam logic [1:0] OP_ROL = 2'b00, OP_SLL = 2'b01, OP_ROR = 2'b10, OP_SRL = 2'b11;

    typedef struct {
        logic        id;
        logic [15:0] data;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0, errors = 0, cyc = 0;
    int          acc_cnt[2];
    int          acc_cyc = 0;
    int          rdy_mode = 0;
    logic        model_free = 1'b1, rr = 1'b0, first = 1'b1;
    logic [15:0] held_data;
    logic        held_id;

    shift_sched dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_amt0(req_amt0), .req_op0(req_op0),
        .req_a1(req_a1), .req_amt1(req_amt1), .req_op1(req_op1),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_ready(rsp_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Reference: rotate via a doubled word, logical shifts zero-fill.
    function automatic logic [15:0] ref_shift(input logic [15:0] a, input int s, input logic [1:0] op);
        logic [31:0] d;
        logic [31:0] t;
        logic [15:0] r;
        d = {a, a};
        case (op)
            OP_ROL: begin t = d << s; r = t[31:16]; end
            OP_SLL: r = a << s;
            OP_ROR: begin t = d >> s; r = t[15:0]; end
            default: r = a >> s;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [3:0] amt);
        return (amt == 0) ? 1 : 1 + $clog2(int'(amt) + 1);
    endfunction

    function automatic logic [1:0] ref_grant(input logic [1:0] v, input logic p);
        if (v == 2'b11) return p ? 2'b10 : 2'b01;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
    endtask

    // Monitor / scoreboard.
    initial begin
        logic [1:0] eg;
        exp_t       e;
        acc_cnt[0] = 0;
        acc_cnt[1] = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_busy", busy, 0);
                chk("rst_rsp_valid", rsp_valid, 0);
                chk("rst_req_ready", req_ready, 0);
                chk("rst_rsp_data", rsp_data, 0);
                chk("rst_rsp_id", rsp_id, 0);
                sb.delete();
                model_free = 1'b1;
                rr = 1'b0;
                first = 1'b1;
            end else begin
                chk("busy", busy, !model_free);
                if (model_free) begin
                    chk("rsp_valid_idle", rsp_valid, 0);
                    eg = ref_grant(req_valid, rr);
                    chk("req_ready", req_ready, eg);
                    if (eg != 2'b00) begin
                        e.id = eg[1];
                        if (eg[1]) begin
                            e.data = ref_shift(req_a1, int'(req_amt1), req_op1);
                            e.lat  = ref_lat(req_amt1);
                        end else begin
                            e.data = ref_shift(req_a0, int'(req_amt0), req_op0);
                            e.lat  = ref_lat(req_amt0);
                        end
                        sb.push_back(e);
                        acc_cnt[eg[1]]++;
                        rr = ~eg[1];
                        model_free = 1'b0;
                        first = 1'b1;
                        acc_cyc = cyc;
                    end
                end else begin
                    chk("req_ready_busy", req_ready, 0);
                    if (rsp_valid) begin
                        if (sb.size() == 0) begin
                            timeout_fail("rsp_unexpected");
                        end else if (first) begin
                            chk("latency", cyc - acc_cyc, sb[0].lat);
                            chk("rsp_data", rsp_data, sb[0].data);
                            chk("rsp_id", rsp_id, sb[0].id);
                            held_data = rsp_data;
                            held_id = rsp_id;
                            first = 1'b0;
                        end else begin
                            chk("rsp_data_stable", rsp_data, held_data);
                            chk("rsp_id_stable", rsp_id, held_id);
                        end
                        if (rsp_ready) begin
                            if (sb.size() != 0) void'(sb.pop_front());
                            model_free = 1'b1;
                        end
                    end else if (!first) begin
                        chk("rsp_valid_drop", rsp_valid, 1);
                    end
                end
            end
        end
    end

    // Response-ready driver: 0 always ready, 1 random, otherwise held low.
    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = 1'($urandom_range(0, 1));
            default: rsp_ready = 1'b0;
        endcase
    end

    task automatic set_req(input int i, input logic [15:0] a, input logic [3:0] amt, input logic [1:0] op);
        if (i == 0) begin req_a0 = a; req_amt0 = amt; req_op0 = op; end
        else        begin req_a1 = a; req_amt1 = amt; req_op1 = op; end
    endtask

    task automatic send(input int i, input logic [15:0] a, input logic [3:0] amt, input logic [1:0] op);
        int start;
        int n;
        start = acc_cnt[i];
        n = 0;
        set_req(i, a, amt, op);
        req_valid[i] = 1'b1;
        while (acc_cnt[i] == start && n < 80) begin
            @(posedge clk);
            #1;
            n++;
        end
        req_valid[i] = 1'b0;
        if (acc_cnt[i] == start) timeout_fail("accept");
    endtask

    task automatic send_both(input logic [15:0] a0, input logic [3:0] m0, input logic [1:0] o0,
                             input logic [15:0] a1, input logic [3:0] m1, input logic [1:0] o1);
        int s0, s1, n;
        s0 = acc_cnt[0];
        s1 = acc_cnt[1];
        n = 0;
        set_req(0, a0, m0, o0);
        set_req(1, a1, m1, o1);
        req_valid = 2'b11;
        while ((acc_cnt[0] == s0 || acc_cnt[1] == s1) && n < 160) begin
            @(posedge clk);
            #1;
            n++;
            if (acc_cnt[0] != s0) req_valid[0] = 1'b0;
            if (acc_cnt[1] != s1) req_valid[1] = 1'b0;
        end
        req_valid = 2'b00;
        if (acc_cnt[0] == s0 || acc_cnt[1] == s1) timeout_fail("accept_both");
    endtask

    task automatic hold_both(input int k);
        int s0, s1, n;
        s0 = acc_cnt[0];
        s1 = acc_cnt[1];
        n = 0;
        req_valid = 2'b11;
        while ((acc_cnt[0] - s0) + (acc_cnt[1] - s1) < k && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        req_valid = 2'b00;
        if ((acc_cnt[0] - s0) + (acc_cnt[1] - s1) < k) timeout_fail("hold_both");
        chk("alternate", acc_cnt[0] - s0, acc_cnt[1] - s1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!model_free && n < 120) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!model_free) timeout_fail("idle");
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int m;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        send(0, 16'h8001, 4'd1, OP_ROL);
        wait_idle();

        rdy_mode = 2;
        send(1, 16'h8000, 4'd15, OP_SRL);
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) timeout_fail("rsp_hold");
        repeat (3) @(negedge clk);
        rdy_mode = 0;
        wait_idle();

        send_both(16'h00FF, 4'd4, OP_SLL, 16'h0001, 4'd1, OP_ROR);
        wait_idle();
        hold_both(6);
        wait_idle();

        send(0, 16'hBEEF, 4'd0, OP_SRL);
        wait_idle();

        send(0, 16'h1234, 4'd8, OP_ROR);
        req_a0 = 16'hFFFF;
        req_amt0 = 4'd1;
        wait_idle();

        // Reset while the engine is mid-shift: the in-flight result is dropped.
        send(0, 16'hABCD, 4'd15, OP_ROL);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("rst_now_busy", busy, 0);
        chk("rst_now_rsp_valid", rsp_valid, 0);
        chk("rst_now_req_ready", req_ready, 0);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        rst_n = 1'b1;
        send_both(16'h0F0F, 4'd3, OP_ROL, 16'hF000, 4'd12, OP_SRL);
        wait_idle();

        rdy_mode = 1;
        for (int i = 0; i < 40; i++) begin
            m = $urandom_range(1, 3);
            if (m == 3)
                send_both(16'($urandom()), 4'($urandom()), 2'($urandom()),
                          16'($urandom()), 4'($urandom()), 2'($urandom()));
            else
                send(m - 1, 16'($urandom()), 4'($urandom()), 2'($urandom()));
        end
        wait_idle();
        rdy_mode = 0;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
